msg_tx: RTL and testbench
=========================

Name: msg_tx

Overview:
- Transmit-side counterpart of the inbound message parser.
- Accepts a message stream in the parser-output format (valid/start/end/mod/data) and buffers it in an internal FIFO.
- Serialises each complete frame onto the inbound word bus (DataValid/LastWord/DataMod/Data with DataAck handshake).
- Serves as the traffic source for loopback, and as the uplink toward the far-end receiver.

Parameters:
- WordWidth, 64, data word width in bits
- Bits, 3, DataMod width; log2(WordWidth/8)
- AddrBits, 4, FIFO address width; depth = 2^AddrBits words

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input word present
- in_start  in  1  first word of message
- in_end  in  1  last word of message
- in_mod  in  Bits  valid bytes in last word, 0 = all valid
- in_data  in  WordWidth  input word
- in_ready  out  1  buffer can accept a word this cycle
- tx_DataValid  out  1  word on tx bus valid
- tx_LastWord  out  1  current tx word ends the frame
- tx_DataMod  out  Bits  byte count for the last word; 0 on non-last words
- tx_Data  out  WordWidth  tx word
- tx_DataAck  in  1  receiver accepts the current word
- tx_err  out  1  one-cycle pulse on an input protocol violation
- frames_pending  out  AddrBits+1  complete frames held in the FIFO

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0 except in_ready.
  - in_ready is 0 while reset is asserted and 1 from the first clock after release.
  - FIFO pointers, frame count and FSM (IDLE) are cleared.
  - Reset mid-frame discards all buffered data; no partial frame is emitted after reset.
- Input write:
  - A word is accepted when in_valid & in_ready. in_ready = !fifo_full.
  - A FIFO entry stores {end, mod, data}. mod is forced to 0 when end=0.
  - open_frame flag: set on an accepted in_start, cleared on an accepted in_end. A single-word frame has start and end in the same word.
  - Accepted word with open_frame=0 and in_start=0: discarded, tx_err pulses.
  - Accepted in_start with open_frame=1: in_start is ignored, the word is written as a continuation, tx_err pulses.
- Frame counter:
  - +1 on a written end word; -1 on a transmitted last word (tx_DataValid & tx_DataAck & tx_LastWord).
  - Both in the same cycle: unchanged.
  - Never wraps: max = 2^AddrBits.
- Transmit FSM:
  - IDLE: go to SEND when frames_pending>0, or when fifo_full & frames_pending==0 (cut-through, for frames longer than the depth).
  - SEND: tx_DataValid=1 with the FIFO head on tx_Data/tx_LastWord/tx_DataMod.
    - Outputs are registered and held stable until tx_DataAck is sampled 1.
    - Each ack pops one word; the next word is presented on the following cycle with no bubble, if the FIFO is non-empty.
    - Acked last word: go to GAP.
    - FIFO empty during cut-through: tx_DataValid drops to 0 and the FSM stays in SEND until more words arrive.
  - GAP: tx_DataValid=0 for exactly one cycle, then return to IDLE.
- Latency: end word written at edge N -> tx_DataValid=1 after edge N+2. This is the earliest case, with the FSM in IDLE.
- tx_DataAck while tx_DataValid=0 is ignored.
- Simultaneous FIFO read and write when full: the write is refused (in_ready=0 that cycle). Full/empty use an extra pointer bit.

Test Plan:
- Single 3-word frame, mods 0/0/5, ack held high:
  - tx words appear on consecutive cycles starting 2 cycles after the end write.
  - LastWord=1 and DataMod=5 on word 3 only.
  - frames_pending returns to 0.
- Ack backpressure: ack toggles 1,0,0,1 on a 4-word frame -> tx_Data is held stable during the low cycles and the word order is preserved.
- Two back-to-back frames (2 and 1 words) -> exactly one idle cycle between them; frames_pending peaks at 2.
- Frame of 20 words with AddrBits=4 and ack held low until full:
  - in_ready drops at 16 words and cut-through starts.
  - When ack is released, all 20 words are emitted in order, LastWord on word 20.
- Protocol errors: a data word without start -> tx_err pulse, word absent from output; start mid-frame -> tx_err pulse, frame continues intact.
- Reset asserted mid-transmission of a 4-word frame after 2 acks:
  - Outputs go to 0 immediately, frames_pending=0.
  - After release, the next frame is transmitted cleanly.

Source files
------------

// File: rtl/msg_tx.sv
// msg_tx: transmit-side message buffer. Accepts parser-format words
// (valid/start/end/mod/data), stores them in a FIFO and replays each
// complete frame on the DataValid/LastWord/DataMod/Data bus with an
// ack handshake. Frames too long for the FIFO are sent cut-through.
module msg_tx #(
  parameter int WordWidth = 64,
  parameter int Bits      = 3,
  parameter int AddrBits  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_start,
  input  logic                 in_end,
  input  logic [Bits-1:0]      in_mod,
  input  logic [WordWidth-1:0] in_data,
  output logic                 in_ready,
  output logic                 tx_DataValid,
  output logic                 tx_LastWord,
  output logic [Bits-1:0]      tx_DataMod,
  output logic [WordWidth-1:0] tx_Data,
  input  logic                 tx_DataAck,
  output logic                 tx_err,
  output logic [AddrBits:0]    frames_pending
);

  localparam int Depth = 1 << AddrBits;
  localparam int EntW  = 1 + Bits + WordWidth;
  localparam logic [AddrBits:0] PtrOne    = {{AddrBits{1'b0}}, 1'b1};
  localparam logic [AddrBits:0] FramesMax = {1'b1, {AddrBits{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                state_r, state_next_s;
  logic [EntW-1:0]       mem_r [Depth];
  logic [AddrBits:0]     wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
  logic [AddrBits:0]     count_s, count_next_s, rd_ptr_p1_s;
  logic [AddrBits:0]     frames_r, frames_s;
  logic                  open_frame_r, open_frame_s;
  logic                  in_ready_r, tx_err_r, err_s;
  logic                  accept_s, write_s, pop_s, fifo_full_s;
  logic                  frame_in_s, frame_out_s;
  logic [EntW-1:0]       wr_entry_s, head_s, head2_s;
  logic                  tx_valid_r, tx_last_r, valid_next_s, last_next_s;
  logic [Bits-1:0]       tx_mod_r, mod_next_s;
  logic [WordWidth-1:0]  tx_data_r, data_next_s;

  // Occupancy uses the extra pointer bit: a difference of Depth means full.
  assign count_s     = wr_ptr_r - rd_ptr_r;
  assign fifo_full_s = count_s[AddrBits];
  assign rd_ptr_p1_s = rd_ptr_r + PtrOne;
  assign head_s      = mem_r[rd_ptr_r[AddrBits-1:0]];
  assign head2_s     = mem_r[rd_ptr_p1_s[AddrBits-1:0]];

  // Input framing checks, pointer advance and frame-count next state.
  always_comb begin
    accept_s     = in_valid & in_ready_r;
    write_s      = accept_s & (open_frame_r | in_start);
    err_s        = accept_s & ((open_frame_r & in_start) | (~open_frame_r & ~in_start));
    pop_s        = tx_valid_r & tx_DataAck;
    frame_in_s   = write_s & in_end;
    frame_out_s  = pop_s & tx_last_r;
    wr_entry_s   = {in_end, (in_end ? in_mod : {Bits{1'b0}}), in_data};
    wr_ptr_s     = wr_ptr_r;
    rd_ptr_s     = rd_ptr_r;
    open_frame_s = open_frame_r;
    frames_s     = frames_r;
    if (write_s) begin
      wr_ptr_s     = wr_ptr_r + PtrOne;
      open_frame_s = ~in_end;
    end else begin
      wr_ptr_s     = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_s = rd_ptr_p1_s;
    end else begin
      rd_ptr_s = rd_ptr_r;
    end
    count_next_s = wr_ptr_s - rd_ptr_s;
    if (frame_in_s && !frame_out_s && (frames_r != FramesMax)) begin
      frames_s = frames_r + PtrOne;
    end else if (frame_out_s && !frame_in_s && (|frames_r)) begin
      frames_s = frames_r - PtrOne;
    end else begin
      frames_s = frames_r;
    end
  end

  // Transmit FSM next state and next values of the registered tx bus.
  always_comb begin
    state_next_s = state_r;
    valid_next_s = 1'b0;
    last_next_s  = 1'b0;
    mod_next_s   = {Bits{1'b0}};
    data_next_s  = {WordWidth{1'b0}};
    case (state_r)
      IDLE: begin
        if ((|frames_r) || fifo_full_s) begin
          state_next_s = SEND;
        end else begin
          state_next_s = IDLE;
        end
      end
      SEND: begin
        if (tx_valid_r) begin
          if (tx_DataAck) begin
            if (tx_last_r) begin
              state_next_s = GAP;
            end else if (count_s > PtrOne) begin
              // Present the word behind the acked one without a bubble.
              valid_next_s = 1'b1;
              {last_next_s, mod_next_s, data_next_s} = head2_s;
            end else begin
              valid_next_s = 1'b0;
            end
          end else begin
            valid_next_s = 1'b1;
            last_next_s  = tx_last_r;
            mod_next_s   = tx_mod_r;
            data_next_s  = tx_data_r;
          end
        end else if (|count_s) begin
          valid_next_s = 1'b1;
          {last_next_s, mod_next_s, data_next_s} = head_s;
        end else begin
          valid_next_s = 1'b0;
        end
      end
      GAP: begin
        // One dead cycle; a waiting frame is loaded straight away.
        if ((|frames_r) || fifo_full_s) begin
          state_next_s = SEND;
          valid_next_s = 1'b1;
          {last_next_s, mod_next_s, data_next_s} = head_s;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FIFO storage; contents need no reset because the pointers gate use.
  always_ff @(posedge clk) begin
    if (write_s) begin
      mem_r[wr_ptr_r[AddrBits-1:0]] <= wr_entry_s;
    end
  end

  // State, pointers, counters and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      wr_ptr_r     <= {(AddrBits+1){1'b0}};
      rd_ptr_r     <= {(AddrBits+1){1'b0}};
      frames_r     <= {(AddrBits+1){1'b0}};
      open_frame_r <= 1'b0;
      in_ready_r   <= 1'b0;
      tx_err_r     <= 1'b0;
      tx_valid_r   <= 1'b0;
      tx_last_r    <= 1'b0;
      tx_mod_r     <= {Bits{1'b0}};
      tx_data_r    <= {WordWidth{1'b0}};
    end else begin
      state_r      <= state_next_s;
      wr_ptr_r     <= wr_ptr_s;
      rd_ptr_r     <= rd_ptr_s;
      frames_r     <= frames_s;
      open_frame_r <= open_frame_s;
      in_ready_r   <= ~count_next_s[AddrBits];
      tx_err_r     <= err_s;
      tx_valid_r   <= valid_next_s;
      tx_last_r    <= last_next_s;
      tx_mod_r     <= mod_next_s;
      tx_data_r    <= data_next_s;
    end
  end

  assign in_ready       = in_ready_r;
  assign tx_DataValid   = tx_valid_r;
  assign tx_LastWord    = tx_last_r;
  assign tx_DataMod     = tx_mod_r;
  assign tx_Data        = tx_data_r;
  assign tx_err         = tx_err_r;
  assign frames_pending = frames_r;

endmodule

// File: tb/tb_msg_tx.sv
// Bench for msg_tx: queue-based reference of the framing rules plus
// directed and randomized scenarios, each checking its own results.
module tb_msg_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_start, in_end;
  logic [2:0]  in_mod;
  logic [63:0] in_data;
  logic        in_ready;
  logic        tx_DataValid, tx_LastWord;
  logic [2:0]  tx_DataMod;
  logic [63:0] tx_Data;
  logic        tx_DataAck;
  logic        tx_err;
  logic [4:0]  frames_pending;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_err = 0;
  int err_seen = 0;
  logic m_open = 1'b0;
  logic [67:0] exp_q[$];
  logic [67:0] rx_q[$];
  int rx_cyc[$];

  msg_tx #(.WordWidth(64), .Bits(3), .AddrBits(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_start(in_start), .in_end(in_end),
    .in_mod(in_mod), .in_data(in_data), .in_ready(in_ready),
    .tx_DataValid(tx_DataValid), .tx_LastWord(tx_LastWord),
    .tx_DataMod(tx_DataMod), .tx_Data(tx_Data), .tx_DataAck(tx_DataAck),
    .tx_err(tx_err), .frames_pending(frames_pending)
  );

  always #5 clk = ~clk;

  // edge counter used for latency and gap measurements
  always @(posedge clk) cyc <= cyc + 1;

  // reference: words accepted at the coming edge, filtered by framing rules
  always @(negedge clk) begin
    if (!reset) begin
      m_open <= 1'b0;
    end else if (in_valid && in_ready) begin
      if (!m_open && !in_start) begin
        exp_err <= exp_err + 1;
      end else begin
        if (m_open && in_start) exp_err <= exp_err + 1;
        exp_q.push_back({in_end, (in_end ? in_mod : 3'd0), in_data});
        m_open <= !in_end;
      end
    end
  end

  // monitor: words taken by the receiver and error pulses
  always @(negedge clk) begin
    if (tx_DataValid && tx_DataAck) begin
      rx_q.push_back({tx_LastWord, tx_DataMod, tx_Data});
      rx_cyc.push_back(cyc);
    end
    if (tx_err) err_seen <= err_seen + 1;
  end

  task automatic put_word(input logic s, input logic e, input logic [2:0] m, input logic [63:0] d);
    int guard = 0;
    in_valid = 1'b1; in_start = s; in_end = e; in_mod = m; in_data = d;
    @(negedge clk);
    while (!in_ready && guard < 300) begin @(negedge clk); guard++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL put_word in_ready=%0b required 1 after %0d cycles", in_ready, guard);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0; in_mod = 3'd0; in_data = 64'd0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin @(posedge clk); #1; k++; end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0;
    in_mod = 3'd0; in_data = 64'd0; tx_DataAck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, tx_DataValid, tx_LastWord, tx_DataMod, tx_Data, tx_err, frames_pending} !== 76'd0) begin
      errors++;
      $display("FAIL reset_outputs ready=%0b valid=%0b last=%0b data=%h fp=%0d required all 0",
               in_ready, tx_DataValid, tx_LastWord, tx_Data, frames_pending);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release in_ready=%0b required 1", in_ready); end
  endtask

  task automatic test_single_frame;
    int rb = rx_q.size();
    int eb = exp_q.size();
    int end_cyc;
    tx_DataAck = 1'b1;
    put_word(1'b1, 1'b0, 3'd0, {$urandom(), $urandom()});
    put_word(1'b0, 1'b0, 3'd0, {$urandom(), $urandom()});
    put_word(1'b0, 1'b1, 3'd5, {$urandom(), $urandom()});
    end_cyc = cyc;
    wait_rx(rb + 3, 50);
    checks++;
    if (rx_q.size() != rb + 3) begin errors++; $display("FAIL single_count got %0d required %0d", rx_q.size() - rb, 3); end
    if (rx_q.size() >= rb + 3) begin
      checks++;
      if (rx_cyc[rb] != end_cyc + 2) begin errors++; $display("FAIL single_latency got %0d required %0d", rx_cyc[rb] - end_cyc, 2); end
      checks++;
      if (rx_cyc[rb+2] != rx_cyc[rb] + 2) begin errors++; $display("FAIL single_consecutive got %0d required 2", rx_cyc[rb+2] - rx_cyc[rb]); end
      checks++;
      if (rx_q[rb+2][67:64] !== 4'hD || rx_q[rb][67:64] !== 4'h0 || rx_q[rb+1][67:64] !== 4'h0) begin
        errors++; $display("FAIL single_lastmod got %h %h %h required 0 0 d", rx_q[rb][67:64], rx_q[rb+1][67:64], rx_q[rb+2][67:64]);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q[rb+i] !== exp_q[eb+i]) begin errors++; $display("FAIL single_word%0d got %h required %h", i, rx_q[rb+i], exp_q[eb+i]); end
      end
    end
    checks++;
    if (frames_pending !== 5'd0) begin errors++; $display("FAIL single_frames got %0d required 0", frames_pending); end
    tx_DataAck = 1'b0;
  endtask

  task automatic test_backpressure;
    int rb = rx_q.size();
    int eb = exp_q.size();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic held = 1'b0;
    logic [66:0] held_word = 67'd0;
    int k = 0;
    tx_DataAck = 1'b0;
    put_word(1'b1, 1'b0, 3'($urandom_range(0, 7)), {$urandom(), $urandom()});
    put_word(1'b0, 1'b0, 3'($urandom_range(0, 7)), {$urandom(), $urandom()});
    put_word(1'b0, 1'b0, 3'($urandom_range(0, 7)), {$urandom(), $urandom()});
    put_word(1'b0, 1'b1, 3'($urandom_range(0, 7)), {$urandom(), $urandom()});
    while (rx_q.size() < rb + 4 && k < 60) begin
      @(posedge clk); #1;
      tx_DataAck = pat[k % 4];
      @(negedge clk);
      if (held && tx_DataValid) begin
        checks++;
        if ({tx_LastWord, tx_DataMod, tx_Data} !== held_word) begin
          errors++; $display("FAIL bp_hold got %h required %h", {tx_LastWord, tx_DataMod, tx_Data}, held_word);
        end
      end
      held = tx_DataValid && !tx_DataAck;
      held_word = {tx_LastWord, tx_DataMod, tx_Data};
      k++;
    end
    tx_DataAck = 1'b0;
    wait_rx(rb + 4, 10);
    checks++;
    if (rx_q.size() != rb + 4) begin errors++; $display("FAIL bp_count got %0d required 4", rx_q.size() - rb); end
    if (rx_q.size() >= rb + 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rx_q[rb+i] !== exp_q[eb+i]) begin errors++; $display("FAIL bp_word%0d got %h required %h", i, rx_q[rb+i], exp_q[eb+i]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int rb = rx_q.size();
    int eb = exp_q.size();
    int peak;
    int k = 0;
    tx_DataAck = 1'b1;
    put_word(1'b1, 1'b0, 3'($urandom_range(0, 7)), {$urandom(), $urandom()});
    put_word(1'b0, 1'b1, 3'($urandom_range(0, 7)), {$urandom(), $urandom()});
    put_word(1'b1, 1'b1, 3'($urandom_range(0, 7)), {$urandom(), $urandom()});
    peak = int'(frames_pending);
    while (rx_q.size() < rb + 3 && k < 40) begin
      @(posedge clk); #1;
      if (int'(frames_pending) > peak) peak = int'(frames_pending);
      k++;
    end
    wait_rx(rb + 3, 10);
    checks++;
    if (peak != 2) begin errors++; $display("FAIL b2b_peak got %0d required 2", peak); end
    checks++;
    if (rx_q.size() != rb + 3) begin errors++; $display("FAIL b2b_count got %0d required 3", rx_q.size() - rb); end
    if (rx_q.size() >= rb + 3) begin
      checks++;
      if (rx_cyc[rb+1] - rx_cyc[rb] != 1) begin errors++; $display("FAIL b2b_intra got %0d required 1", rx_cyc[rb+1] - rx_cyc[rb]); end
      checks++;
      if (rx_cyc[rb+2] - rx_cyc[rb+1] != 2) begin errors++; $display("FAIL b2b_gap got %0d required 2", rx_cyc[rb+2] - rx_cyc[rb+1]); end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q[rb+i] !== exp_q[eb+i]) begin errors++; $display("FAIL b2b_word%0d got %h required %h", i, rx_q[rb+i], exp_q[eb+i]); end
      end
    end
    checks++;
    if (frames_pending !== 5'd0) begin errors++; $display("FAIL b2b_frames got %0d required 0", frames_pending); end
    tx_DataAck = 1'b0;
  endtask

  task automatic test_cut_through;
    int rb = rx_q.size();
    int eb = exp_q.size();
    tx_DataAck = 1'b0;
    for (int i = 0; i < 16; i++) put_word(i == 0, 1'b0, 3'($urandom_range(0, 7)), {$urandom(), $urandom()});
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL ct_full in_ready=%0b required 0", in_ready); end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (tx_DataValid !== 1'b1 || frames_pending !== 5'd0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL ct_start valid=%0b fp=%0d ready=%0b required 1 0 0", tx_DataValid, frames_pending, in_ready);
    end
    if (exp_q.size() > eb) begin
      checks++;
      if (tx_Data !== exp_q[eb][63:0]) begin errors++; $display("FAIL ct_head got %h required %h", tx_Data, exp_q[eb][63:0]); end
    end
    tx_DataAck = 1'b1;
    for (int i = 16; i < 20; i++) put_word(1'b0, i == 19, 3'($urandom_range(0, 7)), {$urandom(), $urandom()});
    wait_rx(rb + 20, 200);
    checks++;
    if (rx_q.size() != rb + 20) begin errors++; $display("FAIL ct_count got %0d required 20", rx_q.size() - rb); end
    if (rx_q.size() >= rb + 20) begin
      for (int i = 0; i < 20; i++) begin
        checks++;
        if (rx_q[rb+i] !== exp_q[eb+i]) begin errors++; $display("FAIL ct_word%0d got %h required %h", i, rx_q[rb+i], exp_q[eb+i]); end
      end
      checks++;
      if (rx_q[rb+19][67] !== 1'b1) begin errors++; $display("FAIL ct_last got %0b required 1", rx_q[rb+19][67]); end
    end
    tx_DataAck = 1'b0;
  endtask

  task automatic test_protocol_errors;
    int rb = rx_q.size();
    int eb = exp_q.size();
    int e0 = err_seen;
    tx_DataAck = 1'b1;
    put_word(1'b0, 1'b0, 3'd0, 64'hDEAD_BEEF_0BAD_F00D);
    put_word(1'b1, 1'b0, 3'($urandom_range(0, 7)), {$urandom(), $urandom()});
    put_word(1'b1, 1'b0, 3'($urandom_range(0, 7)), {$urandom(), $urandom()});
    put_word(1'b0, 1'b1, 3'($urandom_range(1, 7)), {$urandom(), $urandom()});
    wait_rx(rb + 3, 40);
    checks++;
    if (err_seen - e0 != 2) begin errors++; $display("FAIL perr_pulses got %0d required 2", err_seen - e0); end
    checks++;
    if (rx_q.size() != rb + 3) begin errors++; $display("FAIL perr_count got %0d required 3", rx_q.size() - rb); end
    if (rx_q.size() >= rb + 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q[rb+i] !== exp_q[eb+i]) begin errors++; $display("FAIL perr_word%0d got %h required %h", i, rx_q[rb+i], exp_q[eb+i]); end
      end
    end
    tx_DataAck = 1'b0;
  endtask

  task automatic test_random;
    for (int b = 0; b < 3; b++) begin
      int rb = rx_q.size();
      int eb = exp_q.size();
      int nf = $urandom_range(1, 4);
      int total = 0;
      int k = 0;
      tx_DataAck = 1'b0;
      for (int f = 0; f < nf; f++) begin
        int len = $urandom_range(1, 3);
        for (int w = 0; w < len; w++) begin
          put_word(w == 0, w == len - 1, 3'($urandom_range(0, 7)), {$urandom(), $urandom()});
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        total += len;
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (int'(frames_pending) != nf) begin errors++; $display("FAIL rnd%0d_frames got %0d required %0d", b, frames_pending, nf); end
      while (rx_q.size() < rb + total && k < 300) begin
        @(posedge clk); #1;
        tx_DataAck = ($urandom_range(0, 3) != 0);
        k++;
      end
      tx_DataAck = 1'b0;
      wait_rx(rb + total, 10);
      checks++;
      if (rx_q.size() != rb + total) begin errors++; $display("FAIL rnd%0d_count got %0d required %0d", b, rx_q.size() - rb, total); end
      if (rx_q.size() >= rb + total) begin
        for (int i = 0; i < total; i++) begin
          checks++;
          if (rx_q[rb+i] !== exp_q[eb+i]) begin errors++; $display("FAIL rnd%0d_word%0d got %h required %h", b, i, rx_q[rb+i], exp_q[eb+i]); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int rb = rx_q.size();
    int eb = exp_q.size();
    int k = 0;
    tx_DataAck = 1'b0;
    for (int i = 0; i < 4; i++) put_word(i == 0, i == 3, 3'($urandom_range(0, 7)), {$urandom(), $urandom()});
    tx_DataAck = 1'b1;
    while (rx_q.size() < rb + 2 && k < 40) begin @(posedge clk); #1; k++; end
    tx_DataAck = 1'b0;
    checks++;
    if (tx_DataValid !== 1'b1) begin errors++; $display("FAIL rst_pre valid=%0b required 1", tx_DataValid); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({tx_DataValid, tx_LastWord, tx_DataMod, tx_Data, tx_err, in_ready, frames_pending} !== 76'd0) begin
      errors++; $display("FAIL rst_mid valid=%0b data=%h ready=%0b fp=%0d required all 0", tx_DataValid, tx_Data, in_ready, frames_pending);
    end
    checks++;
    if (rx_q.size() != rb + 2) begin errors++; $display("FAIL rst_acks got %0d required 2", rx_q.size() - rb); end
    else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rx_q[rb+i] !== exp_q[eb+i]) begin errors++; $display("FAIL rst_word%0d got %h required %h", i, rx_q[rb+i], exp_q[eb+i]); end
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    rb = rx_q.size();
    eb = exp_q.size();
    tx_DataAck = 1'b1;
    put_word(1'b1, 1'b0, 3'($urandom_range(0, 7)), {$urandom(), $urandom()});
    put_word(1'b0, 1'b1, 3'($urandom_range(0, 7)), {$urandom(), $urandom()});
    wait_rx(rb + 2, 40);
    checks++;
    if (rx_q.size() != rb + 2) begin errors++; $display("FAIL rst_after_count got %0d required 2", rx_q.size() - rb); end
    else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (rx_q[rb+i] !== exp_q[eb+i]) begin errors++; $display("FAIL rst_after_word%0d got %h required %h", i, rx_q[rb+i], exp_q[eb+i]); end
      end
    end
    tx_DataAck = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_cut_through();
    test_protocol_errors();
    test_random();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
